// File: rtl/vga_framebuffer.sv
// Character-cell colour RAM: CPU/fill-engine port A, VGA scan-out port B.
// One colour byte per 16x16 cell, four cells packed per 32-bit word.
`timescale 1ns/1ps
module vga_framebuffer #(
  parameter int          DEPTH     = 300,
  parameter int          AW        = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_2800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        fill_busy,
  input  logic [31:0] vaddr,
  output logic [31:0] vdata
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [31:0]   FB_END = BASE_ADDR + 32'(4 * DEPTH);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] fill_ptr;
  logic [7:0]    fill_colour;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [AW-1:0] vidx;
  logic          in_fb;
  logic          is_ctrl;
  logic          in_v;
  logic          filling;
  logic          cpu_wr;
  logic          start;
  logic [31:0]   rd_word;
  logic [31:0]   merged;

  assign off       = cpu_addr - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign in_fb     = (cpu_addr >= BASE_ADDR) && (cpu_addr < FB_END);
  assign is_ctrl   = cpu_addr[31:2] == CTRL_ADDR[31:2];
  assign filling   = state == FILL;
  assign fill_busy = filling;
  assign cpu_stall = filling & (cpu_we | cpu_re) & in_fb;
  assign cpu_wr    = cpu_we & in_fb & ~filling;
  assign start     = cpu_we & is_ctrl & cpu_wdata[8] & ~filling;
  assign vidx      = vaddr[AW+1:2];
  assign in_v      = vaddr[31:2] < 30'(DEPTH);
  assign rd_word   = mem[idx];

  // Byte-lane merge: the word as it will look after this CPU write.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++)
      if (cpu_be[i]) merged[8*i +: 8] = cpu_wdata[8*i +: 8];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: if (fill_ptr == LAST) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (filling)
      mem[fill_ptr] <= {4{fill_colour}};
    else if (cpu_wr)
      mem[idx] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fill_ptr    <= '0;
      fill_colour <= '0;
      cpu_rdata   <= '0;
      vdata       <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        fill_colour <= cpu_wdata[7:0];
        fill_ptr    <= '0;
      end else if (filling) begin
        fill_ptr <= fill_ptr + AW'(1);
      end
      // A combined write+read returns the freshly written word.
      if (cpu_re & ~cpu_stall) begin
        if (in_fb)
          cpu_rdata <= cpu_we ? merged : rd_word;
        else if (is_ctrl)
          cpu_rdata <= {16'b0, fill_colour, 7'b0, filling};
        else
          cpu_rdata <= '0;
      end
      vdata <= in_v ? mem[vidx] : '0;
    end
  end

endmodule
